// File: rtl/ship_motion_pkg.sv
// Shared types and helpers for the ship motion block: FSM state, speed code
// and the saturating magnitude used by the per-axis tilt filters.
package ship_motion_pkg;

  localparam int SAMPLE_W = 16;
  localparam int SUM_W    = 18;
  localparam int HIST_N   = 4;

  typedef enum logic {FILL, RUN} state_t;

  typedef enum logic [1:0] {
    SPD_ZERO = 2'd0,
    SPD_SLOW = 2'd1,
    SPD_FAST = 2'd2
  } step_t;

  // |v| with the most negative value pinned to the most positive one
  function automatic logic [SAMPLE_W-1:0] abs_sat(input logic signed [SAMPLE_W-1:0] v);
    if (v == {1'b1, {(SAMPLE_W-1){1'b0}}}) return {1'b0, {(SAMPLE_W-1){1'b1}}};
    if (v[SAMPLE_W-1]) return -v;
    return v;
  endfunction

endpackage

// File: rtl/tilt_axis_filter.sv
// One tilt axis: 4-sample moving average with a running sum, then dead-zone
// and two-level speed classification. dir=1 means the average is negative.
module tilt_axis_filter import ship_motion_pkg::*; #(
  parameter int DEAD_ZONE   = 64,
  parameter int FAST_THRESH = 256
) (
  input  logic                       clk_pix,
  input  logic                       reset_n,
  input  logic                       data_update,
  input  logic signed [SAMPLE_W-1:0] data,
  output step_t                      step,
  output logic                       dir
);

  localparam logic [SAMPLE_W-1:0] DZ = SAMPLE_W'(DEAD_ZONE);
  localparam logic [SAMPLE_W-1:0] FT = SAMPLE_W'(FAST_THRESH);

  logic [HIST_N-1:0][SAMPLE_W-1:0] hist;
  logic signed [SUM_W-1:0]         sum;
  logic signed [SAMPLE_W-1:0]      avg;
  logic                            vld_q;
  logic [SAMPLE_W-1:0]             mag;

  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      hist  <= '0;
      sum   <= '0;
      avg   <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= data_update;
      if (data_update) begin
        hist <= {hist[HIST_N-2:0], data};
        sum  <= sum + SUM_W'(data) - SUM_W'($signed(hist[HIST_N-1]));
      end
      // avg trails sum by one cycle, so a frame in the update cycle sees the old value
      if (vld_q) avg <= SAMPLE_W'(sum >>> 2);
    end
  end

  assign mag = abs_sat(avg);
  assign dir = avg[SAMPLE_W-1];

  always_comb begin
    step = SPD_ZERO;
    if (mag > DZ) step = (mag >= FT) ? SPD_FAST : SPD_SLOW;
  end

endmodule

// File: rtl/ship_motion.sv
// Tilt-to-position controller for the spaceship sprite: two filtered axes,
// a fill/run FSM, and a per-frame clamped position update with home override.
module ship_motion import ship_motion_pkg::*; #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int SCREEN_CORDW = 16,
  parameter int SHIP_W       = 34,
  parameter int SHIP_H       = 36,
  parameter int X_HOME       = 300,
  parameter int Y_HOME       = 240,
  parameter int DEAD_ZONE    = 64,
  parameter int FAST_THRESH  = 256,
  parameter int STEP_SLOW    = 1,
  parameter int STEP_FAST    = 3
) (
  input  logic                    clk_pix,
  input  logic                    reset_n,
  input  logic                    data_update,
  input  logic [15:0]             data_x,
  input  logic [15:0]             data_y,
  input  logic                    frame,
  input  logic                    home,
  input  logic                    en,
  output logic [SCREEN_CORDW-1:0] sprite_x,
  output logic [SCREEN_CORDW-1:0] sprite_y,
  output logic                    moving
);

  localparam int NUM_AXES = 2;
  localparam int PW       = SCREEN_CORDW + 1;
  localparam int X_MAX    = H_RES - SHIP_W;
  localparam int Y_MAX    = V_RES - SHIP_H;

  logic [NUM_AXES-1:0][SAMPLE_W-1:0] axis_data;
  logic [NUM_AXES-1:0][1:0]          axis_step;
  logic [NUM_AXES-1:0]               axis_dir;

  assign axis_data = {data_y, data_x};

  for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
    step_t step_q;
    tilt_axis_filter #(
      .DEAD_ZONE   (DEAD_ZONE),
      .FAST_THRESH (FAST_THRESH)
    ) u_filt (
      .clk_pix     (clk_pix),
      .reset_n     (reset_n),
      .data_update (data_update),
      .data        (axis_data[a]),
      .step        (step_q),
      .dir         (axis_dir[a])
    );
    assign axis_step[a] = step_q;
  end

  state_t     state, state_nxt;
  logic [1:0] fill_cnt;
  logic       run;

  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      state    <= FILL;
      fill_cnt <= 2'd0;
    end else begin
      state <= state_nxt;
      if (data_update && state == FILL) fill_cnt <= fill_cnt + 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == FILL && data_update && fill_cnt == 2'd3) state_nxt = RUN;
  end

  always_comb begin
    run = (state == RUN);
  end

  function automatic logic signed [PW-1:0] step_px(input logic [1:0] code);
    case (code)
      SPD_SLOW: return PW'(STEP_SLOW);
      SPD_FAST: return PW'(STEP_FAST);
      default:  return '0;
    endcase
  endfunction

  function automatic logic [SCREEN_CORDW-1:0] clamp(input logic signed [PW-1:0] v, input int hi);
    if (v[PW-1]) return '0;
    if (v > PW'(hi)) return SCREEN_CORDW'(hi);
    return v[SCREEN_CORDW-1:0];
  endfunction

  logic signed [PW-1:0]    x_cur, y_cur, dx_px, dy_px, x_nxt, y_nxt;
  logic [SCREEN_CORDW-1:0] x_cl, y_cl;

  // screen x grows right, so positive x tilt moves left; y follows the tilt sign
  always_comb begin
    x_cur = $signed({1'b0, sprite_x});
    y_cur = $signed({1'b0, sprite_y});
    dx_px = step_px(axis_step[0]);
    dy_px = step_px(axis_step[1]);
    x_nxt = axis_dir[0] ? x_cur + dx_px : x_cur - dx_px;
    y_nxt = axis_dir[1] ? y_cur - dy_px : y_cur + dy_px;
    x_cl  = clamp(x_nxt, X_MAX);
    y_cl  = clamp(y_nxt, Y_MAX);
  end

  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      sprite_x <= SCREEN_CORDW'(X_HOME);
      sprite_y <= SCREEN_CORDW'(Y_HOME);
      moving   <= 1'b0;
    end else if (home) begin
      sprite_x <= SCREEN_CORDW'(X_HOME);
      sprite_y <= SCREEN_CORDW'(Y_HOME);
      moving   <= 1'b0;
    end else if (frame) begin
      if (en && run) begin
        sprite_x <= x_cl;
        sprite_y <= y_cl;
        moving   <= (x_cl != sprite_x) || (y_cl != sprite_y);
      end else begin
        moving <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ship_motion.sv
// Self-checking bench for ship_motion: directed scenarios plus random traffic
// compared each cycle against a sample-list reference model.
module tb_ship_motion;

  logic        clk_pix = 1'b0;
  logic        reset_n = 1'b0, data_update = 1'b0, frame = 1'b0, home = 1'b0, en = 1'b0;
  logic [15:0] data_x = '0, data_y = '0;
  logic [15:0] sprite_x, sprite_y;
  logic        moving;

  always #5 clk_pix = ~clk_pix;

  ship_motion dut (
    .clk_pix     (clk_pix),
    .reset_n     (reset_n),
    .data_update (data_update),
    .data_x      (data_x),
    .data_y      (data_y),
    .frame       (frame),
    .home        (home),
    .en          (en),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .moving      (moving)
  );

  localparam int XMAX = 640 - 34;
  localparam int YMAX = 480 - 36;

  int errors = 0, checks = 0, cyc = 0;
  int qc[$], qx[$], qy[$];
  int mx = 300, my = 240;
  logic mm = 1'b0;

  // mean of the last four samples accepted at least two cycles before t (floor)
  function automatic int model_avg(input int axis, input int t);
    int s = 0, n = 0;
    for (int i = qc.size() - 1; i >= 0 && n < 4; i--)
      if (qc[i] <= t - 2) begin
        s += (axis == 0) ? qx[i] : qy[i];
        n++;
      end
    return (s - (((s % 4) + 4) % 4)) / 4;
  endfunction

  function automatic int speed(input int avg);
    int a;
    a = (avg < 0) ? -avg : avg;
    if (a > 32767) a = 32767;
    if (a <= 64) return 0;
    if (a < 256) return 1;
    return 3;
  endfunction

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic tick(input logic rn, input logic du, input logic [15:0] dx, input logic [15:0] dy,
                      input logic fr, input logic hm, input logic e);
    int ax, ay, nx, ny;
    reset_n = rn; data_update = du; data_x = dx; data_y = dy; frame = fr; home = hm; en = e;
    if (!rn) begin
      qc.delete(); qx.delete(); qy.delete();
      mx = 300; my = 240; mm = 1'b0;
    end else begin
      if (hm) begin
        mx = 300; my = 240; mm = 1'b0;
      end else if (fr) begin
        if (e && qc.size() >= 4) begin
          ax = model_avg(0, cyc);
          ay = model_avg(1, cyc);
          nx = (ax > 0) ? mx - speed(ax) : mx + speed(ax);
          ny = (ay > 0) ? my + speed(ay) : my - speed(ay);
          nx = clampi(nx, XMAX);
          ny = clampi(ny, YMAX);
          mm = (nx != mx) || (ny != my);
          mx = nx; my = ny;
        end else begin
          mm = 1'b0;
        end
      end
      if (du) begin
        qc.push_back(cyc);
        qx.push_back(int'($signed(dx)));
        qy.push_back(int'($signed(dy)));
      end
    end
    @(posedge clk_pix); #1;
    cyc++;
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({sprite_x, sprite_y, moving} !== {16'd300, 16'd240, 1'b0}) begin
      errors++;
      $display("FAIL reset got x=%0d y=%0d mv=%b want x=300 y=240 mv=0", sprite_x, sprite_y, moving);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 0, 0, 1, 0, 1);
      checks++;
      if ({sprite_x, sprite_y, moving} !== {16'd300, 16'd240, 1'b0}) begin
        errors++;
        $display("FAIL idle_frame[%0d] got x=%0d y=%0d mv=%b want x=300 y=240 mv=0", i, sprite_x, sprite_y, moving);
      end
    end
  endtask

  task automatic test_slow_step();
    for (int i = 0; i < 4; i++) tick(1, 1, 16'd200, 16'd0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0, 1, 0, 1);
      checks++;
      if ({sprite_x, sprite_y, moving} !== {16'(299 - i), 16'd240, 1'b1}) begin
        errors++;
        $display("FAIL slow_step[%0d] got x=%0d y=%0d mv=%b want x=%0d y=240 mv=1", i, sprite_x, sprite_y, moving, 299 - i);
      end
      tick(1, 0, 0, 0, 0, 0, 1);
    end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 4; i++) tick(1, 1, 16'hFE70, 16'd0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 106; i++) begin
      tick(1, 0, 0, 0, 1, 0, 1);
      checks++;
      if ({sprite_x, sprite_y, moving} !== {16'(mx), 16'(my), mm}) begin
        errors++;
        $display("FAIL clamp_walk[%0d] got x=%0d y=%0d mv=%b want x=%0d y=%0d mv=%b", i, sprite_x, sprite_y, moving, mx, my, mm);
      end
      tick(1, 0, 0, 0, 0, 0, 1);
    end
    checks++;
    if ({sprite_x, moving} !== {16'd606, 1'b0}) begin
      errors++;
      $display("FAIL clamp_pinned got x=%0d mv=%b want x=606 mv=0", sprite_x, moving);
    end
  endtask

  task automatic test_dead_zone();
    logic [15:0] seq [8] = '{16'd100, 16'd100, 16'hFF9C, 16'hFF9C, 16'd50, 16'd50, 16'd50, 16'd50};
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) tick(1, 1, seq[g*4+i], 16'd0, 0, 0, 1);
      tick(1, 0, 0, 0, 0, 0, 1);
      tick(1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
        tick(1, 0, 0, 0, 1, 0, 1);
        checks++;
        if ({sprite_x, sprite_y, moving} !== {16'd606, 16'd240, 1'b0}) begin
          errors++;
          $display("FAIL dead_zone[%0d.%0d] got x=%0d y=%0d mv=%b want x=606 y=240 mv=0", g, i, sprite_x, sprite_y, moving);
        end
      end
    end
  endtask

  task automatic test_home();
    for (int i = 0; i < 4; i++) tick(1, 1, 16'hFE70, 16'd400, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 1, 1, 1);
    checks++;
    if ({sprite_x, sprite_y, moving} !== {16'd300, 16'd240, 1'b0}) begin
      errors++;
      $display("FAIL home_force got x=%0d y=%0d mv=%b want x=300 y=240 mv=0", sprite_x, sprite_y, moving);
    end
    tick(1, 0, 0, 0, 1, 0, 1);
    checks++;
    if ({sprite_x, sprite_y, moving} !== {16'd303, 16'd243, 1'b1}) begin
      errors++;
      $display("FAIL home_resume got x=%0d y=%0d mv=%b want x=303 y=243 mv=1", sprite_x, sprite_y, moving);
    end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 4; i++) tick(1, 1, 16'd400, 16'd0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 1, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 16'd400, 16'd0, 0, 0, 1);
      tick(1, 0, 0, 0, 0, 0, 1);
      tick(1, 0, 0, 0, 0, 0, 1);
      tick(1, 0, 0, 0, 1, 0, 1);
      checks++;
      if ({sprite_x, sprite_y, moving} !== {16'd300, 16'd240, 1'b0}) begin
        errors++;
        $display("FAIL refill[%0d] got x=%0d y=%0d mv=%b want x=300 y=240 mv=0", i, sprite_x, sprite_y, moving);
      end
    end
    tick(1, 1, 16'd400, 16'd0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 1, 0, 1);
    checks++;
    if ({sprite_x, sprite_y, moving} !== {16'd297, 16'd240, 1'b1}) begin
      errors++;
      $display("FAIL rerun got x=%0d y=%0d mv=%b want x=297 y=240 mv=1", sprite_x, sprite_y, moving);
    end
  endtask

  function automatic logic [15:0] pick();
    int vals [12] = '{0, 64, 65, 255, 256, -64, -65, -255, -256, -32768, 32767, 400};
    if ($urandom_range(0, 1) == 1) return 16'(vals[$urandom_range(0, 11)]);
    return 16'($urandom);
  endfunction

  task automatic test_random();
    logic rn, du, fr, hm, e;
    logic [15:0] dx, dy;
    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 400) != 0);
      du = ($urandom_range(0, 2) == 0);
      fr = ($urandom_range(0, 2) == 0);
      hm = ($urandom_range(0, 40) == 0);
      e  = ($urandom_range(0, 9) != 0);
      dx = pick();
      dy = pick();
      tick(rn, du, dx, dy, fr, hm, e);
      checks++;
      if ({sprite_x, sprite_y, moving} !== {16'(mx), 16'(my), mm}) begin
        errors++;
        $display("FAIL random[%0d] got x=%0d y=%0d mv=%b want x=%0d y=%0d mv=%b", i, sprite_x, sprite_y, moving, mx, my, mm);
      end
    end
  endtask

  initial begin
    test_reset();
    test_slow_step();
    test_clamp();
    test_dead_zone();
    test_home();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
